// File: rtl/cpu_pkg.sv
// Shared opcode encoding (same values the ALU decodes), sequencer state and op-class types.
// The op_class helper groups opcodes by the execute path they take through the sequencer.
package cpu_pkg;

  localparam logic [4:0] OP_LDW  = 5'b00000;
  localparam logic [4:0] OP_LDWI = 5'b00001;
  localparam logic [4:0] OP_STW  = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BRN  = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef enum logic [2:0] {IDLE, T_Y, T_WAIT, T_EX, T_WB, T_HI} state_t;

  typedef enum logic [2:0] {CL_ALU, CL_MEM, CL_BRN, CL_MULDIV, CL_NOP, CL_HALT, CL_ILL} op_class_t;

  function automatic op_class_t op_class(input logic [4:0] op);
    op_class_t cls;
    case (op)
      OP_LDW, OP_LDWI, OP_STW:                     cls = CL_MEM;
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR,
      OP_ROL, OP_AND, OP_OR, OP_ADDI, OP_ANDI,
      OP_ORI, OP_NEG, OP_NOT:                      cls = CL_ALU;
      OP_MUL, OP_DIV:                              cls = CL_MULDIV;
      OP_BRN:                                      cls = CL_BRN;
      OP_NOP:                                      cls = CL_NOP;
      OP_HALT:                                     cls = CL_HALT;
      default:                                     cls = CL_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_exec_sequencer_settle_counter.sv
// 6-bit settle counter: load wins over decrement, decrement saturates at zero.
// zero is combinational from the count register.
module settle_counter (
  input  logic       clock,
  input  logic       clear,
  input  logic       load,
  input  logic       dec,
  input  logic [5:0] load_val,
  output logic       zero
);

  logic [5:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = load_val;
    else if (dec && count_q != 6'd0)
      count_d = count_q - 6'd1;
  end

  always_ff @(posedge clock) begin
    if (!clear)
      count_q <= 6'd0;
    else
      count_q <= count_d;
  end

  assign zero = (count_q == 6'd0);

endmodule

// File: rtl/alu_exec_sequencer.sv
// Execute-phase sequencer: one opcode per start/ready handshake, Moore strobes registered from next state.
// Done latency 2/3 cycles (nop-halt-illegal / single-cycle), N+4 for mul/div; starts while not ready are dropped.
import cpu_pkg::*;

module alu_exec_sequencer #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 34
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       start,
  input  logic [4:0] opcode,
  output logic       ready,
  output logic       busy,
  output logic [4:0] alu_opcode,
  output logic       yin,
  output logic       zin,
  output logic       zlowout,
  output logic       zhighout,
  output logic       rc_wr,
  output logic       lo_wr,
  output logic       hi_wr,
  output logic       pc_wr,
  output logic       mar_wr,
  output logic       done,
  output logic       illegal,
  output logic       halted
);

  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  state_t     state_q, state_d;
  logic [4:0] alu_opcode_q, alu_opcode_d;
  logic       halted_q, halted_d;
  logic       ready_q, ready_d, busy_q, busy_d;
  logic       yin_q, yin_d, zin_q, zin_d, zlowout_q, zlowout_d, zhighout_q, zhighout_d;
  logic       rc_wr_q, rc_wr_d, lo_wr_q, lo_wr_d, hi_wr_q, hi_wr_d;
  logic       pc_wr_q, pc_wr_d, mar_wr_q, mar_wr_d, done_q, done_d, illegal_q, illegal_d;
  logic       cnt_load, cnt_dec, cnt_zero;
  logic [5:0] cnt_val;
  op_class_t  cls;
  logic       exec_op;

  settle_counter u_settle (
    .clock    (clock),
    .clear    (clear),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    alu_opcode_d = alu_opcode_q;
    halted_d     = halted_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_val      = 6'd0;
    cls          = op_class(alu_opcode_q);
    exec_op      = (cls == CL_ALU) || (cls == CL_MEM) || (cls == CL_BRN) || (cls == CL_MULDIV);

    case (state_q)
      IDLE: begin
        if (start && ready_q) begin
          alu_opcode_d = opcode;
          state_d      = T_Y;
        end
      end
      T_Y: begin
        case (cls)
          CL_MULDIV: begin
            cnt_load = 1'b1;
            cnt_val  = (alu_opcode_q == OP_MUL) ? MUL_LOAD : DIV_LOAD;
            state_d  = T_WAIT;
          end
          CL_NOP, CL_ILL: state_d = T_WB;
          CL_HALT: begin
            halted_d = 1'b1;
            state_d  = T_WB;
          end
          default: state_d = T_EX;
        endcase
      end
      T_WAIT: begin
        if (cnt_zero)
          state_d = T_EX;
        else
          cnt_dec = 1'b1;
      end
      T_EX:    state_d = T_WB;
      T_WB:    state_d = (cls == CL_MULDIV) ? T_HI : IDLE;
      T_HI:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the state being entered, so they flop in with it.
    ready_d    = (state_d == IDLE) && !halted_d;
    busy_d     = (state_d != IDLE);
    yin_d      = (state_d == T_Y);
    zin_d      = (state_d == T_EX);
    zlowout_d  = (state_d == T_WB) && exec_op;
    rc_wr_d    = (state_d == T_WB) && (cls == CL_ALU);
    mar_wr_d   = (state_d == T_WB) && (cls == CL_MEM);
    pc_wr_d    = (state_d == T_WB) && (cls == CL_BRN);
    lo_wr_d    = (state_d == T_WB) && (cls == CL_MULDIV);
    zhighout_d = (state_d == T_HI);
    hi_wr_d    = (state_d == T_HI);
    done_d     = ((state_d == T_WB) && (cls != CL_MULDIV)) || (state_d == T_HI);
    illegal_d  = (state_d == T_WB) && (cls == CL_ILL);
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q      <= IDLE;
      alu_opcode_q <= OP_NOP;
      halted_q     <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      yin_q        <= 1'b0;
      zin_q        <= 1'b0;
      zlowout_q    <= 1'b0;
      zhighout_q   <= 1'b0;
      rc_wr_q      <= 1'b0;
      lo_wr_q      <= 1'b0;
      hi_wr_q      <= 1'b0;
      pc_wr_q      <= 1'b0;
      mar_wr_q     <= 1'b0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_opcode_q <= alu_opcode_d;
      halted_q     <= halted_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      yin_q        <= yin_d;
      zin_q        <= zin_d;
      zlowout_q    <= zlowout_d;
      zhighout_q   <= zhighout_d;
      rc_wr_q      <= rc_wr_d;
      lo_wr_q      <= lo_wr_d;
      hi_wr_q      <= hi_wr_d;
      pc_wr_q      <= pc_wr_d;
      mar_wr_q     <= mar_wr_d;
      done_q       <= done_d;
      illegal_q    <= illegal_d;
    end
  end

  assign ready      = ready_q;
  assign busy       = busy_q;
  assign alu_opcode = alu_opcode_q;
  assign halted     = halted_q;
  assign yin        = yin_q;
  assign zin        = zin_q;
  assign zlowout    = zlowout_q;
  assign zhighout   = zhighout_q;
  assign rc_wr      = rc_wr_q;
  assign lo_wr      = lo_wr_q;
  assign hi_wr      = hi_wr_q;
  assign pc_wr      = pc_wr_q;
  assign mar_wr     = mar_wr_q;
  assign done       = done_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed bench for alu_exec_sequencer with hand-written per-cycle strobe expectations.
module tb_alu_exec_sequencer;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic [4:0] opcode = 5'b11001;
  logic       ready, busy, yin, zin, zlowout, zhighout, rc_wr, lo_wr, hi_wr;
  logic       pc_wr, mar_wr, done, illegal, halted;
  logic [4:0] alu_opcode;

  int n_checks = 0;
  int n_errors = 0;

  // Strobe vector bit positions: yin zin zlo zhi rc lo hi pc mar done illegal
  localparam logic [10:0] S_NONE = 11'b000_0000_0000;
  localparam logic [10:0] S_YIN  = 11'b100_0000_0000;
  localparam logic [10:0] S_ZIN  = 11'b010_0000_0000;
  localparam logic [10:0] S_ZLO  = 11'b001_0000_0000;
  localparam logic [10:0] S_ZHI  = 11'b000_1000_0000;
  localparam logic [10:0] S_RC   = 11'b000_0100_0000;
  localparam logic [10:0] S_LO   = 11'b000_0010_0000;
  localparam logic [10:0] S_HI   = 11'b000_0001_0000;
  localparam logic [10:0] S_PC   = 11'b000_0000_1000;
  localparam logic [10:0] S_MAR  = 11'b000_0000_0100;
  localparam logic [10:0] S_DONE = 11'b000_0000_0010;
  localparam logic [10:0] S_ILL  = 11'b000_0000_0001;

  logic [10:0] strb;
  assign strb = {yin, zin, zlowout, zhighout, rc_wr, lo_wr, hi_wr, pc_wr, mar_wr, done, illegal};

  alu_exec_sequencer #(.MUL_CYCLES(4), .DIV_CYCLES(34)) dut (
    .clock      (clock),
    .clear      (clear),
    .start      (start),
    .opcode     (opcode),
    .ready      (ready),
    .busy       (busy),
    .alu_opcode (alu_opcode),
    .yin        (yin),
    .zin        (zin),
    .zlowout    (zlowout),
    .zhighout   (zhighout),
    .rc_wr      (rc_wr),
    .lo_wr      (lo_wr),
    .hi_wr      (hi_wr),
    .pc_wr      (pc_wr),
    .mar_wr     (mar_wr),
    .done       (done),
    .illegal    (illegal),
    .halted     (halted)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Check strobes for the current cycle, then advance one cycle.
  task automatic step(input string tag, input logic [10:0] exp);
    check_eq(tag, {21'd0, strb}, {21'd0, exp});
    tick();
  endtask

  // Present one start for a single edge; returns positioned in cycle 1 after acceptance.
  task automatic issue(input logic [4:0] op);
    start  = 1'b1;
    opcode = op;
    tick();
    start  = 1'b0;
    opcode = 5'b11001;
  endtask

  task automatic pulse_clear();
    clear = 1'b0;
    tick();
    clear = 1'b1;
  endtask

  logic seen_lohi;

  initial begin
    // Reset
    tick();
    tick();
    check_eq("rst_ready", {31'd0, ready}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_strobes", {21'd0, strb}, {21'd0, S_NONE});
    check_eq("rst_opcode", {27'd0, alu_opcode}, 32'h19);
    check_eq("rst_halted", {31'd0, halted}, 32'd0);
    clear = 1'b1;
    tick();
    check_eq("post_rst_strobes", {21'd0, strb}, {21'd0, S_NONE});

    // add: yin c1, zin c2, zlo+rc+done c3
    issue(5'b00011);
    check_eq("add_busy_c1", {31'd0, busy}, 32'd1);
    check_eq("add_opc_c1", {27'd0, alu_opcode}, 32'h03);
    step("add_c1", S_YIN);
    step("add_c2", S_ZIN);
    check_eq("add_ready_done", {31'd0, ready}, 32'd0);
    check_eq("add_opc_c3", {27'd0, alu_opcode}, 32'h03);
    step("add_c3", S_ZLO | S_RC | S_DONE);
    check_eq("add_ready_c4", {31'd0, ready}, 32'd1);
    step("add_c4", S_NONE);

    // mul with 4 settle cycles
    issue(5'b01110);
    step("mul_c1", S_YIN);
    for (int c = 2; c <= 5; c++) begin
      check_eq($sformatf("mul_wait_busy_c%0d", c), {31'd0, busy}, 32'd1);
      step($sformatf("mul_wait_c%0d", c), S_NONE);
    end
    step("mul_c6", S_ZIN);
    step("mul_c7", S_ZLO | S_LO);
    step("mul_c8", S_ZHI | S_HI | S_DONE);
    check_eq("mul_ready_c9", {31'd0, ready}, 32'd1);
    step("mul_c9", S_NONE);

    // div interrupted by reset at cycle 20
    seen_lohi = 1'b0;
    issue(5'b01111);
    for (int c = 1; c < 20; c++) begin
      seen_lohi = seen_lohi | lo_wr | hi_wr;
      tick();
    end
    seen_lohi = seen_lohi | lo_wr | hi_wr;
    check_eq("div_busy_c20", {31'd0, busy}, 32'd1);
    pulse_clear();
    check_eq("div_rst_ready", {31'd0, ready}, 32'd1);
    check_eq("div_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("div_rst_strobes", {21'd0, strb}, {21'd0, S_NONE});
    check_eq("div_rst_opcode", {27'd0, alu_opcode}, 32'h19);
    for (int c = 0; c < 40; c++) begin
      seen_lohi = seen_lohi | lo_wr | hi_wr;
      tick();
    end
    check_eq("div_no_lohi", {31'd0, seen_lohi}, 32'd0);

    // jr is illegal: done+illegal at cycle 2
    issue(5'b10011);
    step("jr_c1", S_YIN);
    step("jr_c2", S_DONE | S_ILL);
    step("jr_c3", S_NONE);

    // branch
    issue(5'b10010);
    step("brn_c1", S_YIN);
    step("brn_c2", S_ZIN);
    step("brn_c3", S_ZLO | S_PC | S_DONE);
    step("brn_c4", S_NONE);

    // ldwi goes to MAR
    issue(5'b00001);
    step("ldwi_c1", S_YIN);
    step("ldwi_c2", S_ZIN);
    step("ldwi_c3", S_ZLO | S_MAR | S_DONE);
    step("ldwi_c4", S_NONE);

    // nop: done only, no illegal
    issue(5'b11001);
    step("nop_c1", S_YIN);
    step("nop_c2", S_DONE);
    step("nop_c3", S_NONE);

    // undefined opcode 11111
    issue(5'b11111);
    step("undef_c1", S_YIN);
    step("undef_c2", S_DONE | S_ILL);
    step("undef_c3", S_NONE);

    // start held high: acceptance every 4th edge
    start  = 1'b1;
    opcode = 5'b00011;
    tick();
    for (int c = 1; c <= 12; c++) begin
      check_eq($sformatf("b2b_yin_c%0d", c), {31'd0, yin}, {31'd0, (c % 4) == 1});
      check_eq($sformatf("b2b_done_c%0d", c), {31'd0, done}, {31'd0, (c % 4) == 3});
      tick();
    end
    start  = 1'b0;
    opcode = 5'b11001;
    tick();
    tick();
    tick();
    tick();
    check_eq("b2b_idle", {31'd0, busy}, 32'd0);

    // halt
    issue(5'b11010);
    check_eq("halt_c1_halted", {31'd0, halted}, 32'd0);
    step("halt_c1", S_YIN);
    check_eq("halt_c2_halted", {31'd0, halted}, 32'd1);
    step("halt_c2", S_DONE);
    check_eq("halt_ready", {31'd0, ready}, 32'd0);
    check_eq("halt_busy", {31'd0, busy}, 32'd0);
    start  = 1'b1;
    opcode = 5'b00011;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_eq($sformatf("halt_ignore_c%0d", c), {30'd0, yin, busy}, 32'd0);
    end
    start = 1'b0;
    pulse_clear();
    check_eq("halt_cleared", {31'd0, halted}, 32'd0);
    check_eq("halt_ready_after_clr", {31'd0, ready}, 32'd1);
    issue(5'b00100);
    check_eq("sub_opc", {27'd0, alu_opcode}, 32'h04);
    step("sub_c1", S_YIN);
    step("sub_c2", S_ZIN);
    step("sub_c3", S_ZLO | S_RC | S_DONE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_sequencer.md
Name: alu_exec_sequencer

Overview:
Multi-cycle execute-phase controller for the 32-bit ALU. It accepts one decoded opcode per start/ready handshake and drives the ALU opcode bus. It strobes the Y/Z operand-result registers and sequences writeback to the register file, HI/LO, PC or MAR. Mul/div get a programmable settle window before Z is captured. It sits between the decode stage and the ALU/register datapath.

Parameters:
MUL_CYCLES, 4, settle cycles held in WAIT before Z capture for multiply (1..63)
DIV_CYCLES, 34, settle cycles held in WAIT before Z capture for divide (1..63)

Ports:
clock  in  1  system clock, all state on rising edge
clear  in  1  reset; one clock; reset is synchronous and active-low
start  in  1  request to execute opcode; accepted when start && ready at a clock edge
opcode  in  5  instruction opcode (codebase 5-bit encoding), sampled at acceptance
ready  out  1  1 in IDLE and not halted
busy  out  1  1 in any state other than IDLE
alu_opcode  out  5  latched opcode to ALU; stable from acceptance until return to IDLE
yin  out  1  load Y register (operand A staging)
zin  out  1  load 64-bit Z register from ALU RC
zlowout  out  1  drive Z[31:0] onto bus
zhighout  out  1  drive Z[63:32] onto bus
rc_wr  out  1  register-file write of bus value
lo_wr  out  1  LO register write
hi_wr  out  1  HI register write
pc_wr  out  1  PC write (branch)
mar_wr  out  1  MAR write (ldw/ldwi/stw address)
done  out  1  single-cycle pulse on final cycle of every accepted op
illegal  out  1  qualifies done: opcode not executable by this block
halted  out  1  sticky after halt until reset

Behaviour:
- Reset (clear==0 at an edge): state IDLE, counter 0, alu_opcode 5'b11001 (nop), halted 0. All strobes, done and illegal are 0; ready is 1 and busy is 0. Reset wins over every other event, including mid-operation; no strobe is asserted on the reset cycle or on the cycle after it.
- Strobes are Moore outputs decoded from state. At most one of rc_wr/lo_wr/hi_wr/pc_wr/mar_wr is high in any cycle.
- States: IDLE, T_Y, T_WAIT, T_EX, T_WB, T_HI.
- IDLE: on start && ready, latch opcode and go to T_Y. A start with ready==0 is ignored, not queued.
- T_Y: yin=1. Next state by class:
  - mul (01110) / div (01111): load counter with MUL_CYCLES-1 / DIV_CYCLES-1, go to T_WAIT.
  - nop (11001): go to T_WB with no writes.
  - halt (11010): set halted, go to T_WB.
  - unsupported (jr, jal, in, out, mfhi, mflo, undefined 11011-11111): go to T_WB with illegal.
  - all others: go to T_EX.
- T_WAIT: counter decrements each cycle. At counter==0, go to T_EX. Dwell is exactly MUL_CYCLES / DIV_CYCLES cycles.
- T_EX: zin=1. Go to T_WB.
- T_WB (zlowout=1 for executed ops):
  - add/sub/shr/shl/ror/rol/and/or/neg/not/addi/andi/ori: rc_wr=1, done=1.
  - ldw/ldwi/stw: mar_wr=1, done=1.
  - branch (10010): pc_wr=1, done=1. The ALU resolves brn_flag itself.
  - mul/div: lo_wr=1, no done; go to T_HI.
  - nop/halt/unsupported: no strobes, done=1. illegal=1 only for unsupported.
- T_HI: zhighout=1, hi_wr=1, done=1. Go to IDLE.
- Latency from acceptance edge to the done cycle:
  - single-cycle ops: 3 cycles.
  - nop/halt/illegal: 2 cycles.
  - mul: MUL_CYCLES+4 cycles; div: DIV_CYCLES+4 cycles.
- ready is 0 on the done cycle. Back-to-back acceptance is possible on the edge ending done+1, i.e. one idle cycle minimum between ops.
- When halted: ready=0 and starts are ignored until reset.

Decomposition:
- Shared package cpu_pkg: 5-bit opcode localparams (Addition..halt, same values the ALU decodes) and a state enum/encoding for this FSM.
- Natural sub-module: settle_counter (6-bit load/decrement/zero-flag), instantiated once.

Test Plan:
- Reset then start with opcode=00011 (add) -> yin at cycle 1, zin at cycle 2, zlowout+rc_wr+done at cycle 3; alu_opcode=00011 throughout.
- opcode=01110 with MUL_CYCLES=4 -> T_WAIT 4 cycles; zin at cycle 6; lo_wr at cycle 7; hi_wr+zhighout+done at cycle 8.
- opcode=01111 with DIV_CYCLES=34; clear=0 at cycle 20 -> next cycle IDLE, ready=1, no lo_wr/hi_wr ever asserted.
- opcode=10011 (jr) -> done+illegal at cycle 2, no write strobe; opcode=10010 -> pc_wr+done at cycle 3.
- start held high continuously with add ops -> accepted every 4th cycle; the start during busy is not queued.
- opcode=11010 (halt) -> done at cycle 2, halted=1, later start with 00011 ignored (ready=0) until clear pulse.
